dma_scheduler: RTL
==================

// Module: dma_scheduler
// PURPOSE
//  Shares the single DMA engine between NUM_REQ requesters (compute cores / CSR port).
//  - Holds one command context per requester.
//  - Splits each command into chunks of at most CHUNK_WORDS.
//  - Issues chunks to the engine round-robin, so one long transfer cannot starve the others.
//  - Pulses per-requester done/error when the whole command retires.
// PARAMETERS
//  NUM_REQ        4   number of requester ports (2..8)
//  ADDR_BITS      8   external address width
//  SRAM_ADDR_BITS 11  SRAM tile address width
//  CHUNK_WORDS    8   max words per engine command (1..255)
// PORTS
//  clk              in   1                  clock; all logic on posedge
//  reset_n          in   1                  synchronous, active-low reset
//  req_valid        in   NUM_REQ            per-requester command valid
//  req_ready        out  NUM_REQ            context i free (comb. = ~ctx_active[i])
//  req_direction    in   NUM_REQ            0 = ext->SRAM, 1 = SRAM->ext
//  req_ext_addr     in   NUM_REQ*ADDR_BITS  flattened; slice i = [i*ADDR_BITS +: ADDR_BITS]
//  req_sram_addr    in   NUM_REQ*SRAM_ADDR_BITS  flattened, same slicing
//  req_length       in   NUM_REQ*8          words to move; 0 is legal
//  req_done         out  NUM_REQ            1-cycle pulse: command i fully transferred
//  req_error        out  NUM_REQ            1-cycle pulse: command i aborted by engine error
//  dma_cmd_valid    out  1                  chunk command to engine
//  dma_cmd_direction out 1
//  dma_cmd_ext_addr out  ADDR_BITS
//  dma_cmd_sram_addr out SRAM_ADDR_BITS
//  dma_cmd_length   out  8                  chunk length, 1..CHUNK_WORDS
//  dma_cmd_ready    in   1                  engine accepts when valid&&ready
//  dma_cmd_done     in   1                  engine chunk complete pulse
//  dma_cmd_error    in   1                  engine error pulse
//  busy             out  1                  any context active or FSM not in IDLE
//  grant_id         out  $clog2(NUM_REQ)    requester owning the current or last chunk
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): all ctx_active=0, FSM=IDLE, rr_ptr=NUM_REQ-1.
//   - All outputs 0 except req_ready = all 1s.
//   - Reset mid-transfer discards every context; no done/error pulse is generated.
//  Accept: req_valid[i] && req_ready[i] at posedge latches dir/addrs/length into ctx i.
//   - Sets ctx_active[i]; req_ready[i] is low from the next cycle.
//   - Accepts on several ports in the same cycle are all taken.
//   - length==0: context is not activated; req_done[i] pulses the next cycle; engine untouched.
//  FSM IDLE: if any ctx_active, pick the first active index after rr_ptr (wrapping).
//   - Set grant_id and rr_ptr to it; chunk = min(remaining, CHUNK_WORDS); go to ISSUE.
//   - A context accepted in this same cycle is not eligible until the next cycle.
//  ISSUE: drive dma_cmd_* from ctx[grant_id] with dma_cmd_valid=1.
//   - Hold all fields stable until dma_cmd_valid && dma_cmd_ready.
//   - Deassert dma_cmd_valid the cycle after acceptance; go to WAIT.
//  WAIT: on dma_cmd_done, go to UPDATE. On dma_cmd_error, clear ctx_active[grant_id],
//   pulse req_error[grant_id] next cycle, go to IDLE.
//   - Done and error in the same cycle: error wins.
//  UPDATE (1 cycle): ext_addr += chunk (mod 2^ADDR_BITS), sram_addr += chunk
//   (mod 2^SRAM_ADDR_BITS), remaining -= chunk.
//   - If remaining becomes 0: clear ctx_active, pulse req_done next cycle.
//   - Go to IDLE.
//  req_ready[i] reasserts in the same cycle as its done/error pulse. A new command on i
//   may be accepted that cycle.
//  Fairness: at most one chunk per requester per round while others are active.
//   - A lone active requester is re-granted back-to-back, with IDLE/UPDATE overhead only.
//  Overhead per chunk: 1 cycle IDLE + issue handshake + engine time + 1 cycle UPDATE.
//  dma_cmd_done/error outside WAIT: ignored.
// TESTING
//  1. Single req0: dir0, ext 0x10, sram 0x020, len 20, CHUNK 8 -> engine sees
//     (0x10,0x020,8), (0x18,0x028,8), (0x20,0x030,4); then exactly one req_done[0] pulse.
//  2. req0 len 16 and req2 len 8 accepted same cycle -> grant order 0,2,0.
//     req_done[2] precedes req_done[0].
//  3. Address wrap: ext 0xFC, len 8 -> chunk ext_addr 0xFC, ctx ext_addr ends at 0x04.
//     sram 0x7FC, len 8 -> sram_addr ends at 0x004.
//  4. len 0 on req1 -> req_done[1] pulse 1 cycle later; dma_cmd_valid never asserted.
//  5. Engine pulses dma_cmd_error in WAIT for req3 (len 24, first chunk) -> req_error[3]
//     pulse, no req_done[3]; req_ready[3]=1; other contexts continue.
//  6. reset_n low while in WAIT with 3 contexts active -> next cycle: all req_ready=1,
//     busy=0, dma_cmd_valid=0, no done/error pulses.

Source files
------------

// File: rtl/dma_scheduler_if.sv
// Requester command ports and the single DMA engine command channel.
// The scheduler takes the master view; requesters and engine together take the slave view.
interface dma_scheduler_if #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_BITS      = 8,
  parameter int SRAM_ADDR_BITS = 11
);
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0]                req_direction;
  logic [NUM_REQ*ADDR_BITS-1:0]      req_ext_addr;
  logic [NUM_REQ*SRAM_ADDR_BITS-1:0] req_sram_addr;
  logic [NUM_REQ*8-1:0]              req_length;
  logic [NUM_REQ-1:0]                req_done;
  logic [NUM_REQ-1:0]                req_error;
  logic                              dma_cmd_valid;
  logic                              dma_cmd_direction;
  logic [ADDR_BITS-1:0]              dma_cmd_ext_addr;
  logic [SRAM_ADDR_BITS-1:0]         dma_cmd_sram_addr;
  logic [7:0]                        dma_cmd_length;
  logic                              dma_cmd_ready;
  logic                              dma_cmd_done;
  logic                              dma_cmd_error;

  modport master (
    input  req_valid, req_direction, req_ext_addr, req_sram_addr, req_length,
    input  dma_cmd_ready, dma_cmd_done, dma_cmd_error,
    output req_ready, req_done, req_error,
    output dma_cmd_valid, dma_cmd_direction, dma_cmd_ext_addr, dma_cmd_sram_addr, dma_cmd_length
  );

  modport slave (
    output req_valid, req_direction, req_ext_addr, req_sram_addr, req_length,
    output dma_cmd_ready, dma_cmd_done, dma_cmd_error,
    input  req_ready, req_done, req_error,
    input  dma_cmd_valid, dma_cmd_direction, dma_cmd_ext_addr, dma_cmd_sram_addr, dma_cmd_length
  );
endinterface

// File: rtl/dma_scheduler.sv
// Shares one DMA engine between NUM_REQ requesters: one context per requester,
// commands split into chunks of at most CHUNK_WORDS and issued round-robin.
module dma_scheduler #(
  parameter int  NUM_REQ        = 4,
  parameter int  ADDR_BITS      = 8,
  parameter int  SRAM_ADDR_BITS = 11,
  parameter int  CHUNK_WORDS    = 8,
  localparam int ID_BITS        = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  dma_scheduler_if.master    bus,
  output logic               busy,
  output logic [ID_BITS-1:0] grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  state_t                    state_r;
  logic [NUM_REQ-1:0]        ctx_active_r;
  logic [NUM_REQ-1:0]        ctx_dir_r;
  logic [ADDR_BITS-1:0]      ctx_ext_r  [NUM_REQ];
  logic [SRAM_ADDR_BITS-1:0] ctx_sram_r [NUM_REQ];
  logic [7:0]                ctx_rem_r  [NUM_REQ];
  logic [NUM_REQ-1:0]        done_r;
  logic [NUM_REQ-1:0]        error_r;
  logic [ID_BITS-1:0]        rr_ptr_r;
  logic [ID_BITS-1:0]        grant_r;
  logic [7:0]                chunk_r;
  logic                      cmd_valid_r;
  logic                      cmd_dir_r;
  logic [ADDR_BITS-1:0]      cmd_ext_r;
  logic [SRAM_ADDR_BITS-1:0] cmd_sram_r;
  logic [ID_BITS-1:0]        next_grant_s;
  logic [7:0]                next_chunk_s;

  // First active index strictly after ptr, wrapping; ptr itself is checked last.
  function automatic logic [ID_BITS-1:0] pick_next(input logic [NUM_REQ-1:0] active,
                                                   input logic [ID_BITS-1:0] ptr);
    logic [ID_BITS-1:0] sel;
    int                 idx;
    sel = ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      sel = active[idx] ? ID_BITS'(idx) : sel;
    end
    return sel;
  endfunction

  function automatic logic [7:0] chunk_size(input logic [7:0] rem);
    return (rem > 8'(CHUNK_WORDS)) ? 8'(CHUNK_WORDS) : rem;
  endfunction

  // Round-robin candidate and its chunk length, consumed only in IDLE.
  always_comb begin
    next_grant_s = pick_next(ctx_active_r, rr_ptr_r);
    next_chunk_s = chunk_size(ctx_rem_r[next_grant_s]);
  end

  // Scheduler FSM, command contexts and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      ctx_active_r <= '0;
      ctx_dir_r    <= '0;
      done_r       <= '0;
      error_r      <= '0;
      rr_ptr_r     <= ID_BITS'(NUM_REQ - 1);
      grant_r      <= '0;
      chunk_r      <= 8'd0;
      cmd_valid_r  <= 1'b0;
      cmd_dir_r    <= 1'b0;
      cmd_ext_r    <= '0;
      cmd_sram_r   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        ctx_ext_r[i]  <= '0;
        ctx_sram_r[i] <= '0;
        ctx_rem_r[i]  <= 8'd0;
      end
    end else begin
      done_r  <= '0;
      error_r <= '0;

      case (state_r)
        ST_IDLE: begin
          if (|ctx_active_r) begin
            grant_r     <= next_grant_s;
            rr_ptr_r    <= next_grant_s;
            chunk_r     <= next_chunk_s;
            cmd_valid_r <= 1'b1;
            cmd_dir_r   <= ctx_dir_r[next_grant_s];
            cmd_ext_r   <= ctx_ext_r[next_grant_s];
            cmd_sram_r  <= ctx_sram_r[next_grant_s];
            state_r     <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (bus.dma_cmd_ready) begin
            cmd_valid_r <= 1'b0;
            state_r     <= ST_WAIT;
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        ST_WAIT: begin
          // Error takes priority over a coincident done.
          if (bus.dma_cmd_error) begin
            ctx_active_r[grant_r] <= 1'b0;
            error_r[grant_r]      <= 1'b1;
            state_r               <= ST_IDLE;
          end else if (bus.dma_cmd_done) begin
            state_r <= ST_UPDATE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_UPDATE: begin
          ctx_ext_r[grant_r]  <= ctx_ext_r[grant_r] + ADDR_BITS'(chunk_r);
          ctx_sram_r[grant_r] <= ctx_sram_r[grant_r] + SRAM_ADDR_BITS'(chunk_r);
          ctx_rem_r[grant_r]  <= ctx_rem_r[grant_r] - chunk_r;
          if (ctx_rem_r[grant_r] == chunk_r) begin
            ctx_active_r[grant_r] <= 1'b0;
            done_r[grant_r]       <= 1'b1;
          end else begin
            ctx_active_r[grant_r] <= 1'b1;
          end
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      // Accepts only touch idle contexts, so they never collide with the FSM's retire above.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && !ctx_active_r[i]) begin
          if (bus.req_length[i*8 +: 8] == 8'd0) begin
            done_r[i] <= 1'b1;
          end else begin
            ctx_active_r[i] <= 1'b1;
            ctx_dir_r[i]    <= bus.req_direction[i];
            ctx_ext_r[i]    <= bus.req_ext_addr[i*ADDR_BITS +: ADDR_BITS];
            ctx_sram_r[i]   <= bus.req_sram_addr[i*SRAM_ADDR_BITS +: SRAM_ADDR_BITS];
            ctx_rem_r[i]    <= bus.req_length[i*8 +: 8];
          end
        end
      end
    end
  end

  assign bus.req_ready         = ~ctx_active_r;
  assign bus.req_done          = done_r;
  assign bus.req_error         = error_r;
  assign bus.dma_cmd_valid     = cmd_valid_r;
  assign bus.dma_cmd_direction = cmd_dir_r;
  assign bus.dma_cmd_ext_addr  = cmd_ext_r;
  assign bus.dma_cmd_sram_addr = cmd_sram_r;
  assign bus.dma_cmd_length    = chunk_r;
  assign busy                  = (|ctx_active_r) || (state_r != ST_IDLE);
  assign grant_id              = grant_r;

endmodule
